// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, ALU opcodes and ID/EX payload type
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_ROT = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [2:0]        alu_op;
    logic [3:0]        shamt;
    logic              x;
    logic [REG_W-1:0]  rd;
    logic              we;
    logic              load;
    logic              set_flags;
  } id_ex_t;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] imm);
    return {{(DATA_W-8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - single-source operand resolution, EX > MEM > WB > register file
module fwd_mux #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_en,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rf_data;
    if (src == '0) begin
      data = '0;
    end else if (ex_fwd_en && (ex_rd == src)) begin
      data = ex_data;
    end else if (mem_we && (mem_rd == src)) begin
      data = mem_data;
    end else if (wb_we && (wb_rd == src)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and N/Z/V flags
module id_ex_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [7:0]        id_imm,
  input  logic              id_use_imm,
  input  logic [2:0]        id_alu_op,
  input  logic [3:0]        id_shamt,
  input  logic              id_x,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_set_flags,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op0,
  output logic [DATA_W-1:0] ex_op1,
  output logic [2:0]        ex_alu_op,
  output logic [3:0]        ex_shamt,
  output logic              ex_x,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_we,
  output logic              ex_load,
  output logic              ex_set_flags,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v
);

  import cpu_pkg::*;

  id_ex_t            ex_q;
  id_ex_t            id_d;
  id_ex_t            ex_next;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              ex_fwd_en;
  logic              load_use;
  logic [2:0]        flags_q;

  // A load's result is not ready in EX; it reaches decode through the MEM path instead.
  assign ex_fwd_en = ex_q.valid & ex_q.we & ~ex_q.load;

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src       (id_rs),
    .rf_data   (id_rs_data),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_q.rd),
    .ex_data   (alu_result),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .data      (rs_val)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src       (id_rt),
    .rf_data   (id_rt_data),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_q.rd),
    .ex_data   (alu_result),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .data      (rt_val)
  );

  assign load_use = id_valid & ex_q.valid & ex_q.load & ex_q.we & (ex_q.rd != '0) &
                    ((ex_q.rd == id_rs) | (~id_use_imm & (ex_q.rd == id_rt)));

  assign stall_id = hold | load_use;

  always_comb begin
    id_d           = '0;
    id_d.valid     = id_valid;
    id_d.op0       = rs_val;
    id_d.op1       = id_use_imm ? sext8(id_imm) : rt_val;
    id_d.alu_op    = id_alu_op;
    id_d.shamt     = id_shamt;
    id_d.x         = id_x;
    id_d.rd        = id_rd;
    id_d.we        = id_we;
    id_d.load      = id_load;
    id_d.set_flags = id_set_flags;
  end

  // Flush beats hold; a bubble only kills the control bits and leaves data untouched.
  always_comb begin
    ex_next = ex_q;
    if (flush || (!hold && load_use)) begin
      ex_next.valid     = 1'b0;
      ex_next.we        = 1'b0;
      ex_next.load      = 1'b0;
      ex_next.set_flags = 1'b0;
    end else if (!hold) begin
      ex_next = id_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (ex_q.valid && ex_q.set_flags && !hold) begin
      flags_q <= {alu_n, alu_z, alu_v};
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_op0       = ex_q.op0;
  assign ex_op1       = ex_q.op1;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_shamt     = ex_q.shamt;
  assign ex_x         = ex_q.x;
  assign ex_rd        = ex_q.rd;
  assign ex_we        = ex_q.we;
  assign ex_load      = ex_q.load;
  assign ex_set_flags = ex_q.set_flags;
  assign flag_n       = flags_q[2];
  assign flag_z       = flags_q[1];
  assign flag_v       = flags_q[0];

endmodule
